// File: rtl/fix2float_seq_ctrl.sv
// fix2float_seq_ctrl: multi-cycle signed Q1.(IN_W-1) fraction to IEEE-754 single converter.
// One 4-bit leading-zero detector is reused across the magnitude, one nibble per cycle,
// starting at the most significant nibble.
// Optional macro FIX2FLOAT_RND_EN: round-to-nearest-even with one extra RND cycle;
// when undefined the mantissa is truncated.

// lzd_4bit: leading-zero count of a nibble plus an all-zero flag.
module lzd_4bit (
   input  logic [3:0] nibble,
   output logic [1:0] lzd,
   output logic       all_zero
);

   // Priority-encode the first set bit counting from the MSB.
   always_comb begin
      lzd      = 2'd0;
      all_zero = 1'b0;
      casez (nibble)
         4'b1???: lzd = 2'd0;
         4'b01??: lzd = 2'd1;
         4'b001?: lzd = 2'd2;
         4'b0001: lzd = 2'd3;
         default: all_zero = 1'b1;
      endcase
   end

endmodule

module fix2float_seq_ctrl #(
   parameter int IN_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_data,
   output logic            busy
);

   localparam int NIBBLES = IN_W / 4;
   localparam int K_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int LZ_W    = K_W + 2;
   localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      SCAN,
      NORM,
`ifdef FIX2FLOAT_RND_EN
      RND,
`endif
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              sign_q;
   logic [IN_W-1:0]   raw_q;
   logic [IN_W-1:0]   mag_q;
   logic [K_W-1:0]    k_q;
   logic [LZ_W-1:0]   lz_q;
   logic              zero_q;
   logic [IN_W-1:0]   nibble_vec;
   logic [1:0]        lzd;
   logic              all_zero;
   logic [IN_W-2:0]   norm_frac;
   logic [7:0]        exp_v;
   logic [22:0]       mant_v;

   // The nibble under inspection is brought to the top by shifting 4*k.
   assign nibble_vec = mag_q << {k_q, 2'b00};

   lzd_4bit u_lzd (
      .nibble   (nibble_vec[IN_W-1 -: 4]),
      .lzd      (lzd),
      .all_zero (all_zero)
   );

   // After normalisation the leading one is implicit, so only the bits below it are kept.
   assign norm_frac = (IN_W-1)'(mag_q << lz_q);
   assign exp_v     = 8'd127 - 8'(lz_q);

`ifdef FIX2FLOAT_RND_EN
   logic [IN_W+21:0] frac_ext;
   logic             guard_v;
   logic             sticky_v;
   logic             guard_q;
   logic             sticky_q;

   assign frac_ext = {norm_frac, 23'b0};
   assign mant_v   = frac_ext[IN_W+21 -: 23];
   assign guard_v  = frac_ext[IN_W-2];
   assign sticky_v = |frac_ext[IN_W-3:0];
`else
   assign mant_v = 23'({norm_frac, 23'b0} >> (IN_W - 1));
`endif

   assign in_ready  = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; SCAN leaves on the first nonzero nibble or after the last one.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = ABS;
         ABS:  state_nxt = SCAN;
         SCAN: if (!all_zero || (k_q == K_LAST)) state_nxt = NORM;
`ifdef FIX2FLOAT_RND_EN
         NORM: state_nxt = RND;
         RND:  state_nxt = DONE;
`else
         NORM: state_nxt = DONE;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers; out_data only changes in NORM/RND so it holds through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q   <= 1'b0;
         raw_q    <= '0;
         mag_q    <= '0;
         k_q      <= '0;
         lz_q     <= '0;
         zero_q   <= 1'b0;
         out_data <= 32'h0;
`ifdef FIX2FLOAT_RND_EN
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q <= in_data[IN_W-1];
                  raw_q  <= in_data;
               end
            end
            ABS: begin
               mag_q  <= sign_q ? -raw_q : raw_q;
               k_q    <= '0;
               lz_q   <= '0;
               zero_q <= 1'b0;
            end
            SCAN: begin
               if (!all_zero)          lz_q   <= {k_q, lzd};
               else if (k_q == K_LAST) zero_q <= 1'b1;
               else                    k_q    <= k_q + K_W'(1);
            end
            NORM: begin
               if (zero_q) out_data <= 32'h0;
               else        out_data <= {sign_q, exp_v, mant_v};
`ifdef FIX2FLOAT_RND_EN
               guard_q  <= guard_v & !zero_q;
               sticky_q <= sticky_v;
`endif
            end
`ifdef FIX2FLOAT_RND_EN
            RND: begin
               if (guard_q && (sticky_q || out_data[0])) begin
                  if (&out_data[22:0]) begin
                     out_data[22:0]  <= 23'h0;
                     out_data[30:23] <= out_data[30:23] + 8'd1;
                  end else begin
                     out_data[22:0]  <= out_data[22:0] + 23'd1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fix2float_seq_ctrl.sv
// tb_fix2float_seq_ctrl: directed checks of the fix2float sequencer.
// Follows FIX2FLOAT_RND_EN for the rounding result and the extra latency cycle.
module tb_fix2float_seq_ctrl;

   localparam int IN_W = 32;
`ifdef FIX2FLOAT_RND_EN
   localparam int RND_LAT = 1;
   localparam logic [31:0] EXP_7FFF = 32'h3F80_0000;
`else
   localparam int RND_LAT = 0;
   localparam logic [31:0] EXP_7FFF = 32'h3F7F_FFFF;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_data;
   logic            busy;

   int checks = 0;
   int errors = 0;
   int lat;
   int seen;
   logic [31:0] held;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   fix2float_seq_ctrl #(.IN_W(IN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are sampled.
   task automatic stepClock;
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for in_ready, then present one word for exactly the accepting edge.
   task automatic applyStimulus(input logic [IN_W-1:0] data, input string tag);
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         stepClock();
         w++;
      end
      checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_data  = data;
      in_valid = 1'b1;
      stepClock();
      in_valid = 1'b0;
   endtask

   // Count edges after the accept until out_valid rises, giving up after 30.
   task automatic waitResult(output int cycles);
      cycles = 0;
      do begin
         stepClock();
         cycles++;
      end while (out_valid !== 1'b1 && cycles < 30);
   endtask

   // Full conversion with out_ready high: busy, latency, value, then release to IDLE.
   task automatic convert(input logic [IN_W-1:0] data, input logic [31:0] exp,
                          input int exp_lat, input string tag);
      int c;
      out_ready = 1'b1;
      applyStimulus(data, tag);
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      waitResult(c);
      checkOutput({tag, " latency"}, 32'(c), 32'(exp_lat));
      checkOutput({tag, " data"}, out_data, exp);
      stepClock();
      checkOutput({tag, " valid_drop"}, 32'(out_valid), 32'd0);
      checkOutput({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   // Linear directed sequence.
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      stepClock();
      stepClock();
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_data", out_data, 32'h0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("idle in_ready", 32'(in_ready), 32'd1);

      convert(32'h4000_0000, 32'h3F00_0000, 3 + RND_LAT, "half");
      convert(32'h8000_0000, 32'hBF80_0000, 3 + RND_LAT, "minus_one");
      convert(32'h0000_0001, 32'h3000_0000, 10 + RND_LAT, "lsb");
      convert(32'h0000_0000, 32'h0000_0000, 10 + RND_LAT, "zero");
      convert(32'hFFFF_FFFF, 32'hB000_0000, 10 + RND_LAT, "minus_lsb");
      convert(32'h7FFF_FFFF, EXP_7FFF, 3 + RND_LAT, "max_pos");

      // Back-pressure: result must hold and a second word must be ignored.
      out_ready = 1'b0;
      applyStimulus(32'h4000_0000, "hold");
      waitResult(lat);
      checkOutput("hold latency", 32'(lat), 32'(3 + RND_LAT));
      held = out_data;
      checkOutput("hold data", held, 32'h3F00_0000);
      for (int i = 0; i < 5; i++) begin
         in_data  = 32'h2000_0000;
         in_valid = (i == 2);
         stepClock();
         checkOutput("hold stable", out_data, 32'h3F00_0000);
         checkOutput("hold in_ready", 32'(in_ready), 32'd0);
         checkOutput("hold out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      stepClock();
      out_ready = 1'b0;
      checkOutput("hold release valid", 32'(out_valid), 32'd0);
      checkOutput("hold pulse ignored", 32'(busy), 32'd0);
      convert(32'h2000_0000, 32'h3E80_0000, 3 + RND_LAT, "second");

      // Reset during SCAN abandons the conversion.
      out_ready = 1'b1;
      applyStimulus(32'h0000_0010, "abort");
      stepClock();
      stepClock();
      rst = 1'b1;
      stepClock();
      checkOutput("abort out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort out_data", out_data, 32'h0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort in_ready", 32'(in_ready), 32'd0);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         stepClock();
         if (out_valid === 1'b1) seen++;
      end
      checkOutput("abort no result", 32'(seen), 32'd0);
      convert(32'h2000_0000, 32'h3E80_0000, 3 + RND_LAT, "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
